// File: rtl/io_uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter for the CPU IO space: decodes stores,
// buffers bytes in a small FIFO and exposes a pollable status word.
module io_uart_tx_port #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [4:0] DATA_WORD    = 5'b10000,
    parameter logic [4:0] CTRL_WORD    = 5'b10001
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        write_io_enable,
    output logic [31:0] status,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0]   BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic          push;
    logic          ctrl_wr;
    logic          pop;
    logic          push_ok;
    logic          overrun_set;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overrun;

    state_t        state;
    state_t        state_next;
    logic [15:0]   timer;
    logic [15:0]   timer_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          tx_reg;
    logic          tx_next;
    logic          bit_end;

    logic          unused_bits;

    assign push    = write_io_enable & addr[7] & (addr[6:2] == DATA_WORD);
    assign ctrl_wr = write_io_enable & addr[7] & (addr[6:2] == CTRL_WORD);
    assign unused_bits = ^{addr[31:8], addr[1:0], datain[31:8]};

    assign fifo_full   = (count == DEPTH_C);
    assign fifo_empty  = (count == '0);
    // A full FIFO still accepts a byte when the transmitter pops on the same edge.
    assign push_ok     = push & (~fifo_full | pop);
    assign overrun_set = push & fifo_full & ~pop;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= datain[7:0];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overrun <= ((ctrl_wr & datain[0]) ? 1'b0 : overrun) | overrun_set;
        end
    end

    assign bit_end = (timer == BIT_LAST);

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        pop          = 1'b0;
        unique case (state)
            IDLE: begin
                timer_next = '0;
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_mem[rd_ptr];
                    bit_idx_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_next = '0;
                    state_next = DATA;
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_next = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_next = '0;
                    // Chain straight into the next frame so queued bytes go out gap-free.
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        shift_next   = fifo_mem[rd_ptr];
                        bit_idx_next = '0;
                        state_next   = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_comb begin
        tx_next = 1'b1;
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    assign tx      = tx_reg;
    assign tx_busy = (state != IDLE);
    assign status  = {24'h000000, 4'(count), overrun, fifo_empty, fifo_full, tx_busy};

endmodule
